timer_extract: RTL

Receive-side counterpart of the frame-head timestamp inserter. It watches the byte stream after a detected frame head, captures the 8-byte BCD timestamp (hour/minute/second/sub-second in 100 µs resolution), and validates it. It presents the decoded time with a one-cycle valid strobe, or reports an error code. It sits between the frame-head detector and the downstream record/playback logic.

---
 rtl/timer_extract.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/timer_extract.sv
// timer_extract: captures the 8-byte BCD timestamp that follows a frame head,
// validates it and presents the decoded time with a one-cycle valid strobe,
// or a one-cycle error strobe with a held error code.
// Optional feature macro: TIMER_EXTRACT_BIN_EN adds a sequential BCD-to-binary
// conversion (CONV state) and the time_bin_o port (time in 100 us units).
module timer_extract #(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [7:0]  rd_data_i,
  input  logic        rd_valid_i,
  output logic [39:0] time_o,
`ifdef TIMER_EXTRACT_BIN_EN
  output logic [29:0] time_bin_o,
`endif
  output logic        valid_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {StIdle, StCapt, StCheck, StConv, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] gap_q, gap_d;
  logic [39:0] cap_q, cap_d;   // b4..b0; pad bytes only need a non-zero flag
  logic        pad_q, pad_d;
  logic [39:0] time_q;
  logic        valid_q, err_q;
  logic [1:0]  code_q;
  logic        err_set;
  logic [1:0]  code_set;
  logic        bcd_bad, range_bad;

`ifdef TIMER_EXTRACT_BIN_EN
  logic [1:0]  step_q, step_d;
  logic [29:0] acc_q, acc_d, bin_q, frac;

  function automatic logic [29:0] bcd_to_bin(input logic [7:0] b);
    return 30'(b[7:4]) * 30'd10 + 30'(b[3:0]);
  endfunction

  assign frac = 30'(cap_q[15:12]) * 30'd1000 + 30'(cap_q[11:8]) * 30'd100 +
                30'(cap_q[7:4]) * 30'd10 + 30'(cap_q[3:0]);
`endif

  // Digit and range checks on the captured time bytes.
  always_comb begin
    bcd_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (cap_q[4*i +: 4] > 4'd9) bcd_bad = 1'b1;
    end
    // Hour compared as a BCD byte; only meaningful once the digits are valid.
    range_bad = (cap_q[23:20] > 4'd5) || (cap_q[31:28] > 4'd5) || (cap_q[39:32] > 8'h23);
  end

  // Next-state logic for capture, validation and conversion sequencing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    cap_d    = cap_q;
    pad_d    = pad_q;
    err_set  = 1'b0;
    code_set = 2'd0;
`ifdef TIMER_EXTRACT_BIN_EN
    step_d   = step_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StCapt;
          cnt_d   = '0;
          gap_d   = '0;
          pad_d   = 1'b0;
        end
      end
      StCapt: begin
        if (start_i) begin
          // Restart wins over a coincident byte, which is dropped.
          cnt_d = '0;
          gap_d = '0;
          pad_d = 1'b0;
        end else if (rd_valid_i) begin
          gap_d = '0;
          if (cnt_q < 3'd5) cap_d[{cnt_q, 3'b000} +: 8] = rd_data_i;
          else              pad_d = pad_q | (|rd_data_i);
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = StCheck;
        end else begin
          gap_d = gap_q + 16'd1;
          if (TIMEOUT != 16'd0 && gap_d == TIMEOUT) begin
            state_d  = StIdle;
            err_set  = 1'b1;
            code_set = 2'd3;
          end
        end
      end
      StCheck: begin
        if (bcd_bad || range_bad) begin
          state_d  = StIdle;
          err_set  = 1'b1;
          code_set = 2'd1;
        end else if (pad_q) begin
          state_d  = StIdle;
          err_set  = 1'b1;
          code_set = 2'd2;
        end else begin
`ifdef TIMER_EXTRACT_BIN_EN
          state_d = StConv;
          step_d  = 2'd0;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef TIMER_EXTRACT_BIN_EN
      StConv: begin
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) state_d = StDone;
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef TIMER_EXTRACT_BIN_EN
  // One conversion step per CONV cycle: hours, then minutes, seconds, fraction.
  always_comb begin
    acc_d = acc_q;
    if (state_q == StConv) begin
      unique case (step_q)
        2'd0:    acc_d = bcd_to_bin(cap_q[39:32]);
        2'd1:    acc_d = acc_q * 30'd60 + bcd_to_bin(cap_q[31:24]);
        2'd2:    acc_d = acc_q * 30'd60 + bcd_to_bin(cap_q[23:16]);
        default: acc_d = acc_q * 30'd10000 + frac;
      endcase
    end
  end
`endif

  // State and registered outputs; outputs are decoded from the next state so
  // the strobes land in the same cycle the FSM enters DONE.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gap_q   <= '0;
      cap_q   <= '0;
      pad_q   <= 1'b0;
      time_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
`ifdef TIMER_EXTRACT_BIN_EN
      step_q  <= '0;
      acc_q   <= '0;
      bin_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      cap_q   <= cap_d;
      pad_q   <= pad_d;
      valid_q <= (state_d == StDone);
      err_q   <= err_set;
      if (err_set)                 code_q <= code_set;
      else if (state_d == StDone)  code_q <= 2'd0;
      if (state_d == StDone)       time_q <= cap_q;
`ifdef TIMER_EXTRACT_BIN_EN
      step_q  <= step_d;
      acc_q   <= acc_d;
      if (state_d == StDone)       bin_q <= acc_d;
`endif
    end
  end

  assign time_o     = time_q;
  assign valid_o    = valid_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;
  assign busy_o     = (state_q != StIdle);
`ifdef TIMER_EXTRACT_BIN_EN
  assign time_bin_o = bin_q;
`endif

endmodule
